// File: rtl/base_pkg.sv
// Shared APB definitions for the simple_if_to_apb requester and the APB slave adapters.
// Contents:
//   apb_req_t / apb_resp_t   APB4 request and response structs
//   RESP_*                   2-bit completion codes returned to the memory-side requester
//   apb_mst_state_e          requester FSM states
//   apb_addr()               base + offset address formation, truncated to the paddr width
package base_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef struct packed {
        logic                  psel;
        logic                  penable;
        logic                  pwrite;
        logic [APB_ADDR_W-1:0] paddr;
        logic [APB_DATA_W-1:0] pwdata;
        logic [APB_STRB_W-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] prdata;
        logic                  pready;
        logic                  pslverr;
    } apb_resp_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    // Offset is zero-extended to 64 bits before the add; the sum is cut to the paddr width.
    function automatic logic [APB_ADDR_W-1:0] apb_addr(input logic [63:0] base,
                                                        input logic [63:0] offset);
        logic [63:0] sum;
        sum = base + offset;
        return sum[APB_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/simple_if_to_apb.sv
// APB requester bridging a split read/write memory-request interface onto APB4.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE. Simultaneous read and write
// requests are arbitrated by a 1-bit round-robin pointer (write wins the first tie).
//
// Optional feature macro: SIMPLE_IF_TO_APB_TIMEOUT_EN
//   defined   : ACCESS cycles are counted; after TIMEOUT_CYCLES without pready the transfer
//               aborts with response 2'b11 (read data is left untouched).
//   undefined : ACCESS waits for pready indefinitely.
//
// Ports:
//   clk_i, arst_ni                    clock, asynchronous active-low reset
//   req_o / resp_i                    APB request / response structs
//   mem_we_i, mem_waddr_i,            write request (held until mem_wgnt_o), offset,
//   mem_wdata_i, mem_wstrb_i          data and byte strobes
//   mem_wgnt_o                        write captured (combinational pulse in IDLE)
//   mem_wresp_valid_o, mem_wresp_o    write completion pulse and response code
//   mem_re_i, mem_raddr_i             read request (held until mem_rgnt_o) and offset
//   mem_rgnt_o                        read captured (combinational pulse in IDLE)
//   mem_rvalid_o, mem_rdata_o,        read completion pulse, data (held until the next
//   mem_rresp_o                       read completion) and response code
module simple_if_to_apb
    import base_pkg::*;
#(
    parameter type         req_t          = base_pkg::apb_req_t,
    parameter type         resp_t         = base_pkg::apb_resp_t,
    parameter logic [63:0] MEM_BASE       = '0,
    parameter int unsigned MEM_SIZE       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    output req_t                  req_o,
    input  resp_t                 resp_i,
    input  logic                  mem_we_i,
    input  logic [MEM_SIZE-1:0]   mem_waddr_i,
    input  logic [APB_DATA_W-1:0] mem_wdata_i,
    input  logic [APB_STRB_W-1:0] mem_wstrb_i,
    output logic                  mem_wgnt_o,
    output logic                  mem_wresp_valid_o,
    output logic [1:0]            mem_wresp_o,
    input  logic                  mem_re_i,
    input  logic [MEM_SIZE-1:0]   mem_raddr_i,
    output logic                  mem_rgnt_o,
    output logic                  mem_rvalid_o,
    output logic [APB_DATA_W-1:0] mem_rdata_o,
    output logic [1:0]            mem_rresp_o
);

    apb_mst_state_e state_q, state_d;

    // High when the next tie should go to the write side.
    logic prefer_w_q, prefer_w_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;

    logic                  wresp_valid_q, wresp_valid_d;
    logic [1:0]            wresp_q, wresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [APB_DATA_W-1:0] rdata_q, rdata_d;

    logic grant_w;
    logic [1:0] done_resp;

`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign grant_w   = mem_we_i & (~mem_re_i | prefer_w_q);
    assign done_resp = resp_i.pslverr ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        state_d       = state_q;
        prefer_w_d    = prefer_w_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        wresp_valid_d = 1'b0;
        wresp_d       = wresp_q;
        rvalid_d      = 1'b0;
        rresp_d       = rresp_q;
        rdata_d       = rdata_q;
        mem_wgnt_o    = 1'b0;
        mem_rgnt_o    = 1'b0;
`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (mem_we_i || mem_re_i) begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                    if (grant_w) begin
                        mem_wgnt_o = 1'b1;
                        prefer_w_d = 1'b0;
                        pwrite_d   = 1'b1;
                        paddr_d    = apb_addr(MEM_BASE, 64'(mem_waddr_i));
                        pwdata_d   = mem_wdata_i;
                        pstrb_d    = mem_wstrb_i;
                    end else begin
                        mem_rgnt_o = 1'b1;
                        prefer_w_d = 1'b1;
                        pwrite_d   = 1'b0;
                        paddr_d    = apb_addr(MEM_BASE, 64'(mem_raddr_i));
                        pwdata_d   = '0;
                        pstrb_d    = '0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            ACCESS: begin
                if (resp_i.pready) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        wresp_valid_d = 1'b1;
                        wresp_d       = done_resp;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = done_resp;
                        rdata_d  = resp_i.prdata;
                    end
                end
`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
                else if (timeout_hit) begin
                    // Abort: the slave never answered; read data stays as it was.
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        wresp_valid_d = 1'b1;
                        wresp_d       = RESP_TIMEOUT;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q       <= IDLE;
            prefer_w_q    <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            wresp_valid_q <= 1'b0;
            wresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            prefer_w_q    <= prefer_w_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            wresp_valid_q <= wresp_valid_d;
            wresp_q       <= wresp_d;
            rvalid_q      <= rvalid_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
        end
    end

`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        req_o         = '0;
        req_o.psel    = psel_q;
        req_o.penable = penable_q;
        req_o.pwrite  = pwrite_q;
        req_o.paddr   = paddr_q;
        req_o.pwdata  = pwdata_q;
        req_o.pstrb   = pstrb_q;
    end

    assign mem_wresp_valid_o = wresp_valid_q;
    assign mem_wresp_o       = wresp_q;
    assign mem_rvalid_o      = rvalid_q;
    assign mem_rresp_o       = rresp_q;
    assign mem_rdata_o       = rdata_q;

endmodule

// File: tb/tb_simple_if_to_apb.sv
module tb_simple_if_to_apb;
    import base_pkg::*;

    localparam logic [63:0] BASE = 64'h4000_0000;
    localparam int unsigned TMO  = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    apb_req_t    req;
    apb_resp_t   resp;
    logic        mem_we = 1'b0, mem_re = 1'b0;
    logic [31:0] mem_waddr = '0, mem_raddr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        wgnt, wresp_valid, rgnt, rvalid;
    logic [1:0]  wresp, rresp;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    bit prefer_w = 1'b1;          // model: next tie goes to write
    logic [31:0] exp_rdata = '0;  // model: last completed read data

    simple_if_to_apb #(
        .req_t         (apb_req_t),
        .resp_t        (apb_resp_t),
        .MEM_BASE      (BASE),
        .MEM_SIZE      (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i            (clk),
        .arst_ni          (arst_n),
        .req_o            (req),
        .resp_i           (resp),
        .mem_we_i         (mem_we),
        .mem_waddr_i      (mem_waddr),
        .mem_wdata_i      (mem_wdata),
        .mem_wstrb_i      (mem_wstrb),
        .mem_wgnt_o       (wgnt),
        .mem_wresp_valid_o(wresp_valid),
        .mem_wresp_o      (wresp),
        .mem_re_i         (mem_re),
        .mem_raddr_i      (mem_raddr),
        .mem_rgnt_o       (rgnt),
        .mem_rvalid_o     (rvalid),
        .mem_rdata_o      (rdata),
        .mem_rresp_o      (rresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting in an IDLE cycle; returns in the response cycle (still IDLE).
    task automatic run_xfer(input bit w_req, input bit r_req, input int waits, input bit err,
                            input logic [31:0] prdata_val);
        bit          win_w;
        apb_req_t    exp;
        logic [1:0]  exp_resp;
        logic [63:0] sum;
        win_w    = w_req && (!r_req || prefer_w);
        sum      = BASE + {32'h0, (win_w ? mem_waddr : mem_raddr)};
        exp      = '0;
        exp.psel = 1'b1;
        exp.pwrite = win_w;
        exp.paddr  = sum[31:0];
        exp.pwdata = win_w ? mem_wdata : 32'h0;
        exp.pstrb  = win_w ? mem_wstrb : 4'h0;
        exp_resp   = err ? 2'b10 : 2'b00;

        mem_we = w_req;
        mem_re = r_req;
        #1;
        checks++;
        if (wgnt !== win_w || rgnt !== !win_w) begin
            errors++;
            $display("FAIL grant: wgnt=%b rgnt=%b required %b %b", wgnt, rgnt, win_w, !win_w);
        end
        gnt_cyc = cyc;

        step();
        if (win_w) mem_we = 1'b0;
        else       mem_re = 1'b0;
        checks++;
        if (req !== exp || wgnt !== 1'b0 || rgnt !== 1'b0) begin
            errors++;
            $display("FAIL setup: req=%h gnt=%b%b required %h 00", req, wgnt, rgnt, exp);
        end

        exp.penable = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            step();
            resp.pready  = (i == waits);
            resp.pslverr = (i == waits) ? err : $urandom_range(0, 1);
            resp.prdata  = (i == waits) ? prdata_val : $urandom;
            checks++;
            if (req !== exp || wresp_valid !== 1'b0 || rvalid !== 1'b0) begin
                errors++;
                $display("FAIL access%0d: req=%h valid=%b%b required %h 00",
                         i, req, wresp_valid, rvalid, exp);
            end
        end

        step();
        resp.pready = 1'b0;
        if (!win_w) exp_rdata = prdata_val;
        prefer_w = !win_w;
        checks++;
        if (win_w) begin
            if (wresp_valid !== 1'b1 || rvalid !== 1'b0 || wresp !== exp_resp || req.psel !== 1'b0) begin
                errors++;
                $display("FAIL wresp: valid=%b rvalid=%b resp=%b psel=%b required 1 0 %b 0",
                         wresp_valid, rvalid, wresp, req.psel, exp_resp);
            end
        end else begin
            if (rvalid !== 1'b1 || wresp_valid !== 1'b0 || rresp !== exp_resp ||
                rdata !== exp_rdata || req.psel !== 1'b0) begin
                errors++;
                $display("FAIL rresp: valid=%b wvalid=%b resp=%b data=%h psel=%b required 1 0 %b %h 0",
                         rvalid, wresp_valid, rresp, rdata, req.psel, exp_resp, exp_rdata);
            end
        end
    endtask

    task automatic test_reset();
        resp = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req !== '0 || wgnt !== 1'b0 || rgnt !== 1'b0 || wresp_valid !== 1'b0 ||
            rvalid !== 1'b0 || rdata !== 32'h0 || wresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset: req=%h rdata=%h wresp=%b rresp=%b valid=%b%b required zeros",
                     req, rdata, wresp, rresp, wresp_valid, rvalid);
        end
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_write_waits();
        mem_waddr = 32'h10;
        mem_wdata = 32'hDEAD_BEEF;
        mem_wstrb = 4'hF;
        run_xfer(1'b1, 1'b0, 2, 1'b0, 32'h0);
    endtask

    task automatic test_read_slverr();
        mem_raddr = 32'h20;
        run_xfer(1'b0, 1'b1, 0, 1'b1, 32'h1234_5678);
    endtask

    task automatic test_arbitration();
        // Fresh reset so the first tie must go to write.
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        prefer_w = 1'b1;
        exp_rdata = '0;
        step();
        mem_waddr = 32'h100;
        mem_wdata = 32'h0BAD_F00D;
        mem_wstrb = 4'h3;
        mem_raddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (prefer_w !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL arb_order%0d: model picks %s", k, prefer_w ? "W" : "R");
            end
            run_xfer(1'b1, 1'b1, k, 1'b0, 32'hA000_0000 + k);
        end
        mem_we = 1'b0;
        mem_re = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        mem_waddr = 32'h44;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = 4'h5;
        mem_we    = 1'b1;
        step();   // SETUP
        step();   // ACCESS, pready low
        step();   // ACCESS, pready low
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (req.psel !== 1'b0 || req.penable !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: psel=%b penable=%b required 0 0", req.psel, req.penable);
        end
        step();
        checks++;
        if (wresp_valid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_noresp: wresp_valid=%b rdata=%h required 0 0", wresp_valid, rdata);
        end
        arst_n    = 1'b1;
        prefer_w  = 1'b1;
        exp_rdata = '0;
        run_xfer(1'b1, 1'b0, 1, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int prev;
        mem_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            mem_waddr = 32'h300 + 4 * k;
            mem_wdata = $urandom;
            run_xfer(1'b1, 1'b0, 0, 1'b0, 32'h0);
            if (k > 0) begin
                checks++;
                if (gnt_cyc - prev != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: %0d cycles required 3", k, gnt_cyc - prev);
                end
            end
            prev = gnt_cyc;
        end
    endtask

    task automatic test_random();
        bit w, r, e;
        for (int k = 0; k < 16; k++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) w = 1'b1;
            e = 1'($urandom_range(0, 1));
            mem_waddr = $urandom;
            mem_raddr = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            run_xfer(w, r, $urandom_range(0, 3), e, $urandom);
        end
        mem_we = 1'b0;
        mem_re = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bit bad;
        mem_raddr = 32'h80;
        mem_re    = 1'b1;
        resp      = '0;
        #1;
        checks++;
        if (rgnt !== 1'b1) begin
            errors++;
            $display("FAIL tmo_grant: rgnt=%b required 1", rgnt);
        end
        step();
        mem_re = 1'b0;
        prefer_w = 1'b1;
`ifdef SIMPLE_IF_TO_APB_TIMEOUT_EN
        bad = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            step();
            if (req.psel !== 1'b1 || req.penable !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL tmo_access: ACCESS not held for %0d cycles", TMO);
        end
        step();
        checks++;
        if (req.psel !== 1'b0 || rvalid !== 1'b1 || rresp !== 2'b11 || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL tmo_abort: psel=%b rvalid=%b rresp=%b rdata=%h required 0 1 11 %h",
                     req.psel, rvalid, rresp, rdata, exp_rdata);
        end
`else
        bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (req.psel !== 1'b1 || req.penable !== 1'b1 || rvalid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_tmo: ACCESS not held for 120 cycles without pready");
        end
        resp.pready = 1'b1;
        resp.prdata = 32'hCAFE_0001;
        step();
        resp.pready = 1'b0;
        exp_rdata = 32'hCAFE_0001;
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL no_tmo_done: rvalid=%b rresp=%b rdata=%h required 1 00 %h",
                     rvalid, rresp, rdata, exp_rdata);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_waits();
        test_read_slverr();
        test_arbitration();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
